mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Sequential signed 32-bit multiply/divide unit for the MIPS ALU datapath.
- Accepts operands on a one-cycle start pulse and iterates one bit per cycle.
- Every add/subtract goes through a single shared carry-lookahead adder; the block feeds that adder and consumes its sum each cycle.
- Returns the low result word, an exception flag and a one-cycle ready pulse to the writeback/stall logic.

Parameters:
- WIDTH, 32, operand and result width in bits; counter width is clog2(WIDTH)+1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement
- data_operandB  input  WIDTH  multiplier / divisor, two's complement
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- data_result  output  WIDTH  product low word or quotient
- data_exception  output  1  overflow / divide-by-zero flag
- data_resultRDY  output  1  one-cycle pulse, result valid
- busy  output  1  high while an operation is in flight

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, FSM in IDLE, counter=0.
- FSM states: IDLE, MULT, DIV, DONE.
  - IDLE→MULT on ctrl_MULT; IDLE→DIV on ctrl_DIV.
  - MULT/DIV→DONE when counter reaches WIDTH.
  - DONE→IDLE after one cycle.
- Start: a start pulse sampled at edge T latches both operands, clears the counter and sets busy.
  - ctrl_MULT and ctrl_DIV high together: multiply wins.
- Latency: data_resultRDY is high for exactly one cycle, the cycle following edge T+WIDTH+1 (T+33 for WIDTH=32).
  - busy is high from T+1 through the RDY cycle inclusive.
- Multiply: radix-2 Booth over a 2*WIDTH+1-bit product register.
  - Each cycle, inspect the low two bits: 01 adds the multiplicand to the upper half, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic-shift right by 1. Exactly WIDTH iterations.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2W-1:W] is not all equal to product[W-1] (signed overflow).
- Divide: restoring division on magnitudes, WIDTH iterations.
  - Each iteration: shift remainder/quotient left, trial subtract the divisor magnitude; keep the result if non-negative and set the quotient bit, else restore.
  - Quotient is negated if the operand signs differ (truncate toward zero). Remainder is discarded.
  - Divisor == 0: iterations still run; data_result=0, data_exception=1, same latency.
  - Dividend 0x80000000 with divisor -1: data_result=0x80000000, data_exception=1.
- Adder use: the single adder instance performs all adds, subtracts and negations.
  - Subtract is B inverted with carry-in 1.
  - Sign fix-up uses the adder in the DONE-entry cycle; no second adder.
- Output hold: data_result and data_exception update only at the RDY edge and hold until the next RDY or reset.
- Restart while busy: a new start pulse aborts the current operation, relatches operands and restarts the count.
  - The aborted operation never raises RDY.
  - RDY occurs WIDTH+1 cycles after the new start.
- Start in the DONE cycle: RDY still fires for the finishing operation; the new operation begins normally.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no RDY is emitted.
- Counter never wraps: it saturates at WIDTH and clears on start.

Optional Feature:
- MULT_DIV_DIVIDE_EN defined: the divide datapath and DIV state are built as specified above.
- Undefined: no divide hardware and no DIV state; ctrl_DIV from IDLE goes straight to DONE.
  - RDY pulses one cycle after the start edge (T+1) with data_result=0 and data_exception=1.
  - ctrl_MULT still has priority.

Test Plan:
- ctrl_MULT, A=7, B=-3 (0xFFFFFFFD) at T → RDY at T+33; data_result=0xFFFFFFEB; exception=0; busy deasserts after the RDY cycle.
- ctrl_MULT, A=0x00010000, B=0x00010000 → data_result=0x00000000, exception=1; then A=-1, B=-1 → data_result=1, exception=0.
- (DIVIDE_EN) ctrl_DIV, A=-100, B=7 → data_result=0xFFFFFFF2, exception=0; then A=5, B=0 → data_result=0, exception=1, RDY at T+33.
- (DIVIDE_EN) ctrl_DIV, A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000, exception=1.
- ctrl_MULT 3*4 at T, then ctrl_MULT 6*7 at T+10 → no RDY at T+33; a single RDY at T+43 with data_result=42.
- Reset high for one cycle at T+5 of a multiply → busy=0, data_result=0 next cycle; no RDY within 40 cycles. Without DIVIDE_EN: ctrl_DIV → RDY at T+1, result 0, exception 1.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed Booth multiply / restoring divide over one shared CLA
// Define MULT_DIV_DIVIDE_EN to build the divide datapath and DIV state.

module mult_div_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int LEVELS = $clog2(WIDTH);

  // Kogge-Stone prefix tree; carry-in is folded into bit 0's generate.
  logic [WIDTH-1:0] g_l [LEVELS+1];
  logic [WIDTH-1:0] p_l [LEVELS+1];

  always_comb begin
    g_l[0] = a_i & b_i;
    p_l[0] = a_i ^ b_i;
    g_l[0][0] = (a_i[0] & b_i[0]) | ((a_i[0] ^ b_i[0]) & cin_i);
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      g_l[lvl+1] = g_l[lvl];
      p_l[lvl+1] = p_l[lvl];
      for (int i = (1 << lvl); i < WIDTH; i++) begin
        g_l[lvl+1][i] = g_l[lvl][i] | (p_l[lvl][i] & g_l[lvl][i - (1 << lvl)]);
        p_l[lvl+1][i] = p_l[lvl][i] & p_l[lvl][i - (1 << lvl)];
      end
    end
    sum_o  = p_l[0] ^ {g_l[LEVELS][WIDTH-2:0], cin_i};
    cout_o = g_l[LEVELS][WIDTH-1];
  end
endmodule

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;

`ifdef MULT_DIV_DIVIDE_EN
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
`ifdef MULT_DIV_DIVIDE_EN
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             keep;
`endif
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [WIDTH:0]   upper_ext;
  logic             start_mult, start_div, cnt_done;

  assign start_mult = ctrl_MULT;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;
  assign cnt_done   = (cnt_q == CW'(WIDTH));

  mult_div_cla #(.WIDTH(WIDTH)) u_cla (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULT_DIV_DIVIDE_EN
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_mult) begin
      state_d = S_MULT;
    end else if (start_div) begin
`ifdef MULT_DIV_DIVIDE_EN
      state_d = S_DIV;
`else
      state_d = S_DONE;
`endif
    end else begin
      case (state_q)
        S_MULT:  if (cnt_done) state_d = S_DONE;
`ifdef MULT_DIV_DIVIDE_EN
        S_DIV:   if (cnt_done) state_d = S_DONE;
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    data_resultRDY = (state_q == S_DONE);
    data_result    = result_q;
    data_exception = exc_q;
  end

  // Datapath: a start aborts whatever is running, so the adder is free that cycle.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    exc_d     = exc_q;
    upper_ext = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
`ifdef MULT_DIV_DIVIDE_EN
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    keep      = 1'b0;
`endif
    if (start_mult) begin
      cnt_d  = '0;
      opnd_d = data_operandA;
      prod_d = {{WIDTH{1'b0}}, data_operandB, 1'b0};
    end else if (start_div) begin
      cnt_d = '0;
`ifdef MULT_DIV_DIVIDE_EN
      add_b   = ~data_operandA;
      add_cin = 1'b1;
      opnd_d  = data_operandB;
      a_neg_d = data_operandA[WIDTH-1];
      b_neg_d = data_operandB[WIDTH-1];
      prod_d  = {{WIDTH{1'b0}}, (data_operandA[WIDTH-1] ? add_sum : data_operandA), 1'b0};
`else
      result_d = '0;
      exc_d    = 1'b1;
`endif
    end else if (state_q == S_MULT) begin
      if (!cnt_done) begin
        add_a   = prod_q[PW-1:WIDTH+1];
        add_b   = prod_q[1] ? ~opnd_q : opnd_q;
        add_cin = prod_q[1];
        // Shift in the true sign of the (WIDTH+1)-bit sum so a most-negative multiplicand stays exact.
        if (prod_q[1] != prod_q[0])
          upper_ext = {add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout, add_sum};
        prod_d = {upper_ext, prod_q[WIDTH:1]};
        cnt_d  = cnt_q + CW'(1);
      end else begin
        result_d = prod_q[WIDTH:1];
        exc_d    = (prod_q[PW-1:WIDTH+1] != {WIDTH{prod_q[WIDTH]}});
      end
    end
`ifdef MULT_DIV_DIVIDE_EN
    else if (state_q == S_DIV) begin
      if (!cnt_done) begin
        // Adding 2^W-|B| covers both divisor signs; carry-out or the shifted-out bit means no borrow.
        add_a   = {prod_q[PW-2:WIDTH+1], prod_q[WIDTH]};
        add_b   = b_neg_q ? opnd_q : ~opnd_q;
        add_cin = ~b_neg_q;
        keep    = prod_q[PW-1] | add_cout;
        prod_d  = {(keep ? add_sum : add_a), prod_q[WIDTH-1:1], keep, 1'b0};
        cnt_d   = cnt_q + CW'(1);
      end else begin
        add_b   = ~prod_q[WIDTH:1];
        add_cin = 1'b1;
        if (opnd_q == '0) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          result_d = (a_neg_q ^ b_neg_q) ? add_sum : prod_q[WIDTH:1];
          exc_d    = prod_q[WIDTH] & ~(a_neg_q ^ b_neg_q);
        end
      end
    end
`endif
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           edge_no;
  } exp_t;

  exp_t sb[$];
  int   edge_count = 0;
  int   rdy_seen = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_count <= edge_count + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp_v, edge_count);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY === 1'b1) begin
      rdy_seen++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdy: got result %h at edge %0d, expected no RDY", data_result, edge_count);
      end else begin
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", 32'(data_exception), 32'(e.exc));
        check("rdy_edge", 32'(edge_count), 32'(e.edge_no));
        check("busy_in_rdy", 32'(busy), 32'd1);
      end
    end
  end

  // Called at a negedge; the pulse is sampled by the next rising edge.
  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [W-1:0] er, input logic ee, input int lat);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    if (push) begin
      e.res = er;
      e.exc = ee;
      e.edge_no = edge_count + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
    check("busy_after_rdy", 32'(busy), 32'd0);
  endtask

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] er, input logic ee);
    start_op(1'b1, 1'b0, a, b, 1'b1, er, ee, LAT);
    wait_drain();
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] er, input logic ee);
`ifdef MULT_DIV_DIVIDE_EN
    start_op(1'b0, 1'b1, a, b, 1'b1, er, ee, LAT);
`else
    start_op(1'b0, 1'b1, a, b, 1'b1, er, ee, 0);
`endif
    wait_drain();
  endtask

  initial begin
    int rdy_before;
    repeat (3) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 1'b0, LAT);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_drain();

    do_mult(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    do_mult(32'h00003039, 32'hFFFFFFFF, 32'hFFFFCFC7, 1'b0);
    do_mult(32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1);
    do_mult(32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
    do_mult(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    do_mult(32'h80000000, 32'h00000002, 32'h00000000, 1'b1);

`ifdef MULT_DIV_DIVIDE_EN
    do_div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);
    do_div(32'd5, 32'd0, 32'd0, 1'b1);
    do_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    do_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
    do_div(32'h80000000, 32'd1, 32'h80000000, 1'b0);
    do_div(32'd7, 32'd100, 32'd0, 1'b0);
`else
    do_div(32'd100, 32'd7, 32'd0, 1'b1);
    do_div(32'd5, 32'd0, 32'd0, 1'b1);
`endif

    // Both start pulses together: multiply takes priority.
    start_op(1'b1, 1'b1, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, LAT);
    wait_drain();

    // Restart ten edges into a multiply: only the second one reports.
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, '0, 1'b0, 0);
    repeat (9) @(negedge clock);
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, LAT);
    wait_drain();

    // New start during the DONE cycle: both results are reported.
    start_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0, LAT);
    repeat (33) @(negedge clock);
    check("rdy_at_overlap_start", 32'(data_resultRDY), 32'd1);
    start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0, LAT);
    wait_drain();

    // Reset five edges into a multiply.
    start_op(1'b1, 1'b0, 32'd5, 32'd5, 1'b0, '0, 1'b0, 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", 32'(data_exception), 32'd0);
    rdy_before = rdy_seen;
    repeat (40) @(negedge clock);
    check("no_rdy_after_reset", 32'(rdy_seen), 32'(rdy_before));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
